// File: rtl/ts_pkg.sv
// Shared constants and types for the temperature-sensor AFE responder.
package ts_pkg;

  localparam int DATA_W = 8;
  localparam int INT_W  = 10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic signed [INT_W-1:0] MAX_CODE = 10'sd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } ts_state_e;

  // Clamp a signed internal-width result into the unsigned output code range.
  function automatic logic [DATA_W-1:0] sat_code(input logic signed [INT_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_CODE)
      return '1;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/ts_sync2.sv
// Two-flop synchronizer with a history flop; flags a rising edge of the
// synchronized level for one clk cycle.
module ts_sync2 (
  input  logic clk,
  input  logic RST,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1, s2, hist;

  // Synchronizer chain plus history for edge detection.
  always_ff @(posedge clk) begin
    if (RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~hist;

endmodule

// File: rtl/ts_afe_responder.sv
// Behavioural responder for the temperature-sensor AFE: counts conversion
// steps on D2A_TS_CLK after a frame start and returns an offset-corrected,
// saturated code with a DETOK strobe.
// Optional: define TS_RESP_DITHER_EN to add LFSR dither of {-1,0,0,+1}.
//
// state | meaning
// IDLE  | waiting for a START_EN rising edge with D2A_TS_EN=1
// ARM   | inputs latched, waiting for the first TS_CLK edge
// CONV  | counting TS_CLK edges up to SAR_STEPS
// DONE  | result on DOUT; DETOK held for DETOK_CYC cycles
import ts_pkg::*;

module ts_afe_responder #(
  parameter int SAR_STEPS = 8,
  parameter int DETOK_CYC = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              D2A_TS_EN,
  input  logic              D2A_TS_START_EN,
  input  logic              D2A_TS_CLK,
  input  logic              D2A_TS_CHOPPER_CLK,
  input  logic [DATA_W-1:0] temp_code,
  input  logic [3:0]        ana_offset,
  output logic              A2D_TS_DETOK,
  output logic [DATA_W-1:0] A2D_TS_DOUT,
  output logic              busy
);

  logic start_rise, start_lvl, ts_rise, ts_lvl, chop_lvl, chop_rise;

  ts_sync2 u_sync_start (.clk(clk), .RST(RST), .d(D2A_TS_START_EN),    .level(start_lvl), .rise(start_rise));
  ts_sync2 u_sync_tsclk (.clk(clk), .RST(RST), .d(D2A_TS_CLK),         .level(ts_lvl),    .rise(ts_rise));
  ts_sync2 u_sync_chop  (.clk(clk), .RST(RST), .d(D2A_TS_CHOPPER_CLK), .level(chop_lvl),  .rise(chop_rise));

  ts_state_e         state, state_n;
  logic [4:0]        step_cnt, step_n;
  logic [3:0]        tmr, tmr_n;
  logic [DATA_W-1:0] lat_code, code_n;
  logic [3:0]        lat_off, off_n;
  logic              lat_chop, chop_n;
  logic [DATA_W-1:0] dout_r, dout_n;
  logic              detok_r, detok_n;
  logic              conv_done;

  logic [4:0] step_inc;
  logic       last_step;

  logic signed [INT_W-1:0] code_ext, off_ext, raw, dith;
  logic [DATA_W-1:0]       result;

  assign step_inc  = step_cnt + 5'd1;
  assign last_step = (step_inc == 5'(SAR_STEPS));

  assign code_ext = {{(INT_W-DATA_W){1'b0}}, lat_code};
  assign off_ext  = {{(INT_W-4){lat_off[3]}}, lat_off};
  assign raw      = lat_chop ? (code_ext + off_ext) : (code_ext - off_ext);

`ifdef TS_RESP_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dith    = (lfsr[1:0] == 2'b00) ? -10'sd1 :
                   (lfsr[1:0] == 2'b11) ?  10'sd1 : 10'sd0;

  // Dither source steps once for every conversion that completes.
  always_ff @(posedge clk) begin
    if (RST)
      lfsr <= LFSR_SEED;
    else if (conv_done)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign dith = '0;
`endif

  assign result = sat_code(raw + dith);

  // Next-state and datapath decisions; enable low overrides everything.
  always_comb begin
    state_n   = state;
    step_n    = step_cnt;
    tmr_n     = tmr;
    code_n    = lat_code;
    off_n     = lat_off;
    chop_n    = lat_chop;
    dout_n    = dout_r;
    detok_n   = detok_r;
    conv_done = 1'b0;
    if (!D2A_TS_EN) begin
      state_n = ST_IDLE;
      detok_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ARM, ST_CONV: begin
          // A start edge wins over a coincident step edge, so the first
          // counted step always comes strictly after the latch.
          if (start_rise) begin
            code_n  = temp_code;
            off_n   = ana_offset;
            chop_n  = chop_lvl;
            step_n  = '0;
            state_n = ST_ARM;
          end else if (state != ST_IDLE && ts_rise) begin
            // The ARM->CONV edge is itself step 1 of SAR_STEPS.
            step_n = step_inc;
            if (last_step) begin
              state_n   = ST_DONE;
              dout_n    = result;
              tmr_n     = 4'(DETOK_CYC);
              conv_done = 1'b1;
            end else begin
              state_n = ST_CONV;
            end
          end
        end
        ST_DONE: begin
          if (tmr != 4'd0) begin
            detok_n = 1'b1;
            tmr_n   = tmr - 4'd1;
          end else begin
            detok_n = 1'b0;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      tmr      <= '0;
      lat_code <= '0;
      lat_off  <= '0;
      lat_chop <= 1'b0;
      dout_r   <= '0;
      detok_r  <= 1'b0;
    end else begin
      state    <= state_n;
      step_cnt <= step_n;
      tmr      <= tmr_n;
      lat_code <= code_n;
      lat_off  <= off_n;
      lat_chop <= chop_n;
      dout_r   <= dout_n;
      detok_r  <= detok_n;
    end
  end

  assign A2D_TS_DETOK = detok_r;
  assign A2D_TS_DOUT  = dout_r;
  assign busy         = (state == ST_ARM) || (state == ST_CONV);

  logic unused_ok;
  assign unused_ok = &{1'b0, start_lvl, ts_lvl, chop_rise, conv_done};

endmodule

// File: tb/tb_ts_afe_responder.sv
// Directed self-checking bench for ts_afe_responder (default parameters).
import ts_pkg::*;

module tb_ts_afe_responder;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       D2A_TS_EN = 1'b0;
  logic       D2A_TS_START_EN = 1'b0;
  logic       D2A_TS_CLK = 1'b0;
  logic       D2A_TS_CHOPPER_CLK = 1'b0;
  logic [7:0] temp_code = 8'd0;
  logic [3:0] ana_offset = 4'd0;
  logic       A2D_TS_DETOK;
  logic [7:0] A2D_TS_DOUT;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int detok_rises = 0;
  logic detok_d = 1'b0;

  ts_afe_responder #(.SAR_STEPS(8), .DETOK_CYC(4)) dut (
    .clk(clk), .RST(RST), .D2A_TS_EN(D2A_TS_EN),
    .D2A_TS_START_EN(D2A_TS_START_EN), .D2A_TS_CLK(D2A_TS_CLK),
    .D2A_TS_CHOPPER_CLK(D2A_TS_CHOPPER_CLK), .temp_code(temp_code),
    .ana_offset(ana_offset), .A2D_TS_DETOK(A2D_TS_DETOK),
    .A2D_TS_DOUT(A2D_TS_DOUT), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    detok_d <= A2D_TS_DETOK;
    if (A2D_TS_DETOK && !detok_d) detok_rises <= detok_rises + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    D2A_TS_START_EN = 1'b1; tick(3);
    D2A_TS_START_EN = 1'b0; tick(3);
  endtask

  task automatic ts_pulse();
    D2A_TS_CLK = 1'b1; tick(3);
    D2A_TS_CLK = 1'b0; tick(3);
  endtask

  // Full conversion: 7 step edges, then the 8th edge enters DONE.
  task automatic run_frame(input string tag, input logic [7:0] code, input logic [3:0] off,
                           input logic chop, input logic [7:0] exp, output logic [7:0] got);
    int hi;
    temp_code = code; ana_offset = off; D2A_TS_CHOPPER_CLK = chop; tick(3);
    pulse_start();
    chk({tag, "_busy_arm"}, busy, 1);
    repeat (7) ts_pulse();
    D2A_TS_CLK = 1'b1; tick(3);
    chk({tag, "_dout"}, A2D_TS_DOUT, exp);
    chk({tag, "_detok_pre"}, A2D_TS_DETOK, 0);
    got = A2D_TS_DOUT;
    D2A_TS_CLK = 1'b0;
    hi = 0;
    repeat (10) begin tick(1); if (A2D_TS_DETOK) hi++; end
    chk({tag, "_detok_len"}, hi, 4);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [7:0] d_a, d_b, d_x;
    int base, hi;

    tick(3);
    chk("rst_detok", A2D_TS_DETOK, 0);
    chk("rst_dout", A2D_TS_DOUT, 0);
    chk("rst_busy", busy, 0);
    RST = 1'b0; D2A_TS_EN = 1'b1; tick(2);

    run_frame("chop1", 8'd100, 4'd3, 1'b1, 8'd103, d_a);
    run_frame("chop0", 8'd100, 4'd3, 1'b0, 8'd97, d_b);
    chk("chop_mean", (32'(d_a) + 32'(d_b)) / 2, 100);

    run_frame("sat_hi", 8'd254, 4'd5, 1'b1, 8'd255, d_x);
    run_frame("sat_lo", 8'd2, 4'd5, 1'b0, 8'd0, d_x);
    run_frame("neg_off", 8'd50, 4'hC, 1'b1, 8'd46, d_x);

    // Restart after 5 edges; relatched inputs must drive the result.
    base = detok_rises;
    temp_code = 8'd10; ana_offset = 4'd0; D2A_TS_CHOPPER_CLK = 1'b1; tick(3);
    pulse_start();
    repeat (5) ts_pulse();
    chk("rst_mid_busy", busy, 1);
    temp_code = 8'd20; ana_offset = 4'd2; tick(1);
    pulse_start();
    chk("restart_arm", 32'(dut.state), 32'(ST_ARM));
    repeat (7) ts_pulse();
    chk("restart_no_detok", detok_rises - base, 0);
    chk("restart_busy", busy, 1);
    D2A_TS_CLK = 1'b1; tick(3);
    chk("restart_dout", A2D_TS_DOUT, 22);
    D2A_TS_CLK = 1'b0;
    tick(10);
    chk("restart_one_detok", detok_rises - base, 1);

    // Coincident start and step edges in IDLE: step edge must not count.
    temp_code = 8'd5; ana_offset = 4'd0; tick(1);
    D2A_TS_START_EN = 1'b1; D2A_TS_CLK = 1'b1; tick(3);
    chk("simul_arm", 32'(dut.state), 32'(ST_ARM));
    D2A_TS_START_EN = 1'b0; D2A_TS_CLK = 1'b0; tick(3);
    repeat (7) ts_pulse();
    chk("simul_busy", busy, 1);
    D2A_TS_CLK = 1'b1; tick(3);
    chk("simul_dout", A2D_TS_DOUT, 5);
    D2A_TS_CLK = 1'b0;
    tick(10);

    // Enable drop in the second DONE cycle.
    temp_code = 8'd60; ana_offset = 4'd1; D2A_TS_CHOPPER_CLK = 1'b1; tick(3);
    pulse_start();
    repeat (7) ts_pulse();
    D2A_TS_CLK = 1'b1; tick(3);
    chk("en_dout", A2D_TS_DOUT, 61);
    D2A_TS_CLK = 1'b0; tick(1);
    chk("en_detok_up", A2D_TS_DETOK, 1);
    D2A_TS_EN = 1'b0; tick(1);
    chk("en_detok_cut", A2D_TS_DETOK, 0);
    chk("en_state", 32'(dut.state), 32'(ST_IDLE));
    chk("en_dout_hold", A2D_TS_DOUT, 61);
    D2A_TS_EN = 1'b1; tick(3);

    // Reset mid-CONV.
    base = detok_rises;
    temp_code = 8'd77; ana_offset = 4'd0; tick(1);
    pulse_start();
    repeat (3) ts_pulse();
    chk("rstc_busy_pre", busy, 1);
    RST = 1'b1; tick(1);
    chk("rstc_detok", A2D_TS_DETOK, 0);
    chk("rstc_dout", A2D_TS_DOUT, 0);
    chk("rstc_busy", busy, 0);
    RST = 1'b0; tick(1);
    repeat (8) ts_pulse();
    hi = detok_rises - base;
    tick(6);
    chk("rstc_no_detok", detok_rises - base, 0);
    chk("rstc_no_detok_mid", hi, 0);
    chk("rstc_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
